feinv: RTL

Fermat field inverter for GF(2^255-19): computes out = a^(p-2) mod p by left-to-right square-and-multiply. It is the initiator side of the multiplier start/done handshake. It owns no multiplier: it drives operands and a start pulse into an external femul-style multiplier and consumes its done pulse and result. It sits above the multiplier in the curve25519 datapath and serves the final projective-to-affine conversion.

---
 rtl/feinv.sv | 133 +++++++++++++
 1 files changed

// File: rtl/feinv.sv
// feinv: Fermat inverter out = a^(p-2) mod p over GF(2^255-19), driving an external multiplier.
// Optional build macro FEINV_TIMEOUT_EN adds a per-request mul_done watchdog and the error flag.
`default_nettype none

module feinv #(
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [254:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [254:0] out,
  output logic         error,
  output logic         mul_start,
  output logic [254:0] mul_a,
  output logic [254:0] mul_b,
  input  logic         mul_done,
  input  logic [254:0] mul_out
);

  // Exponent p-2 = 2^255-21
  localparam logic [254:0] EXP = {{250{1'b1}}, 5'b01011};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_ISSUE  = 3'd1,
    SQ_WAIT   = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t       state;
  logic [254:0] base;
  logic [7:0]   idx;

  if (TIMEOUT < 1) begin : g_timeout_check
  end

`ifdef FEINV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // tcnt holds the number of cycles elapsed since the last mul_start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (mul_start) begin
      tcnt <= TW'(1);
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

  // mul_a doubles as the accumulator: every result is either reissued through it or retired to out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      base      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
`ifdef FEINV_TIMEOUT_EN
      error     <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base      <= a_in;
            idx       <= 8'd253;
            busy      <= 1'b1;
            mul_a     <= a_in;
            mul_b     <= a_in;
            mul_start <= 1'b1;
            state     <= SQ_ISSUE;
`ifdef FEINV_TIMEOUT_EN
            error     <= 1'b0;
`endif
          end
        end
        SQ_ISSUE:  state <= SQ_WAIT;
        MUL_ISSUE: state <= MUL_WAIT;
        SQ_WAIT, MUL_WAIT: begin
          if (mul_done) begin
            if (state == SQ_WAIT && EXP[idx]) begin
              mul_a     <= mul_out;
              mul_b     <= base;
              mul_start <= 1'b1;
              state     <= MUL_ISSUE;
            end else if (idx == 8'd0) begin
              out   <= mul_out;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else begin
              idx       <= idx - 8'd1;
              mul_a     <= mul_out;
              mul_b     <= mul_out;
              mul_start <= 1'b1;
              state     <= SQ_ISSUE;
            end
          end
`ifdef FEINV_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            out   <= '0;
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end
`endif
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
